cordic_rotation: RTL and testbench

CORDIC_ROTATION -- requirements
Module: cordic_rotation

---
 rtl/cordic_rotation.sv | 213 +++++++++++++++++++++
 tb/tb_cordic_rotation.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rotation.sv
// Iterative CORDIC rotator: rotates (x_in, y_in) by angle_in, one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to add a COMP cycle that removes the CORDIC gain K.
module cordic_rotation #(
  parameter int WORD_WIDTH = 16,
  parameter int ITERATIONS = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] x_in,
  input  logic [WORD_WIDTH-1:0] y_in,
  input  logic [WORD_WIDTH-1:0] angle_in,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] x_out,
  output logic [WORD_WIDTH-1:0] y_out,
  output logic [WORD_WIDTH-1:0] z_res
);

  localparam int DW = WORD_WIDTH + 2;
  localparam int CW = $clog2(ITERATIONS + 1);

  localparam logic signed [WORD_WIDTH-1:0] Q_POS   = {2'b01, {(WORD_WIDTH-2){1'b0}}};
  localparam logic signed [WORD_WIDTH-1:0] Q_NEG   = {2'b11, {(WORD_WIDTH-2){1'b0}}};
  localparam logic signed [DW-1:0]         SAT_MAX = {3'b000, {(WORD_WIDTH-1){1'b1}}};
  localparam logic signed [DW-1:0]         SAT_MIN = {3'b111, {(WORD_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
`ifdef CORDIC_GAIN_COMP_EN
    S_COMP,
`endif
    S_DONE
  } state_t;

  // atan(2^-i) with pi = 2^31
  function automatic logic [31:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_lut = 32'h2000_0000;
      5'd1:    atan_lut = 32'h12E4_051E;
      5'd2:    atan_lut = 32'h09FB_385B;
      5'd3:    atan_lut = 32'h0511_11D4;
      5'd4:    atan_lut = 32'h028B_0D43;
      5'd5:    atan_lut = 32'h0145_D7E1;
      5'd6:    atan_lut = 32'h00A2_F61E;
      5'd7:    atan_lut = 32'h0051_7C55;
      5'd8:    atan_lut = 32'h0028_BE53;
      5'd9:    atan_lut = 32'h0014_5F2F;
      5'd10:   atan_lut = 32'h000A_2F98;
      5'd11:   atan_lut = 32'h0005_17CC;
      5'd12:   atan_lut = 32'h0002_8BE6;
      5'd13:   atan_lut = 32'h0001_45F3;
      5'd14:   atan_lut = 32'h0000_A2F9;
      5'd15:   atan_lut = 32'h0000_517C;
      5'd16:   atan_lut = 32'h0000_28BE;
      5'd17:   atan_lut = 32'h0000_145F;
      5'd18:   atan_lut = 32'h0000_0A2F;
      5'd19:   atan_lut = 32'h0000_0517;
      5'd20:   atan_lut = 32'h0000_028B;
      5'd21:   atan_lut = 32'h0000_0145;
      default: atan_lut = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [WORD_WIDTH-1:0] sat(input logic signed [DW-1:0] v);
    if (v > SAT_MAX)      sat = {1'b0, {(WORD_WIDTH-1){1'b1}}};
    else if (v < SAT_MIN) sat = {1'b1, {(WORD_WIDTH-1){1'b0}}};
    else                  sat = v[WORD_WIDTH-1:0];
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  // 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9
  function automatic logic signed [DW-1:0] inv_gain(input logic signed [DW-1:0] v);
    inv_gain = (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
  endfunction
`endif

  state_t                        state_q, state_d;
  logic signed [DW-1:0]          x_q, x_d, y_q, y_d;
  logic signed [WORD_WIDTH-1:0]  z_q, z_d;
  logic        [CW-1:0]          cnt_q, cnt_d;
  logic                          busy_q, busy_d, done_q, done_d;
  logic        [WORD_WIDTH-1:0]  x_out_q, x_out_d, y_out_q, y_out_d, z_res_q, z_res_d;

  logic signed [DW-1:0]          xi_e, yi_e, x_sh, y_sh;
  logic signed [WORD_WIDTH-1:0]  ang, atan_w;
`ifdef CORDIC_GAIN_COMP_EN
  logic signed [DW-1:0]          x_sc, y_sc;
  assign x_sc = inv_gain(x_q);
  assign y_sc = inv_gain(y_q);
`endif

  assign xi_e   = {{2{x_in[WORD_WIDTH-1]}}, x_in};
  assign yi_e   = {{2{y_in[WORD_WIDTH-1]}}, y_in};
  assign ang    = angle_in;
  assign x_sh   = x_q >>> cnt_q;
  assign y_sh   = y_q >>> cnt_q;
  assign atan_w = WORD_WIDTH'(atan_lut(5'(cnt_q)) >> (32 - WORD_WIDTH));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    z_res_d = z_res_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ang > Q_POS) begin
            x_d = -yi_e;
            y_d = xi_e;
            z_d = ang - Q_POS;
          end else if (ang < Q_NEG) begin
            x_d = yi_e;
            y_d = -xi_e;
            z_d = ang - Q_NEG;
          end else begin
            x_d = xi_e;
            y_d = yi_e;
            z_d = ang;
          end
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        // One extra ITER cycle at cnt == ITERATIONS hands the finished datapath on.
        if (cnt_q == CW'(ITERATIONS)) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = S_COMP;
`else
          x_out_d = sat(x_q);
          y_out_d = sat(y_q);
          z_res_d = z_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
`endif
        end else begin
          if (!z_q[WORD_WIDTH-1]) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_w;
          end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_w;
          end
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      S_COMP: begin
        x_d     = x_sc;
        y_d     = y_sc;
        x_out_d = sat(x_sc);
        y_out_d = sat(y_sc);
        z_res_d = z_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_out_q <= '0;
      y_out_q <= '0;
      z_res_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      z_res_q <= z_res_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign x_out = x_out_q;
  assign y_out = y_out_q;
  assign z_res = z_res_q;

endmodule

// File: tb/tb_cordic_rotation.sv
// Bench for cordic_rotation: vector table through a result scoreboard, plus
// start-while-busy and mid-rotation reset sequences.
module tb_cordic_rotation;

  localparam int W     = 16;
  localparam int ITERS = 14;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = ITERS + 2;
`else
  localparam int LAT = ITERS + 1;
`endif
  localparam int TOL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  x_in = '0, y_in = '0, angle_in = '0;
  logic          busy, done;
  logic [W-1:0]  x_out, y_out, z_res;

  always #5 clk = ~clk;

  cordic_rotation #(.WORD_WIDTH(W), .ITERATIONS(ITERS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x_in(x_in), .y_in(y_in), .angle_in(angle_in),
    .busy(busy), .done(done),
    .x_out(x_out), .y_out(y_out), .z_res(z_res)
  );

  typedef struct {
    int xi, yi, ai;
    int ex_nc, ey_nc;
    int ex_c, ey_c;
  } vec_t;

  typedef struct {
    int    ex, ey;
    string name;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done = 0;

  task automatic check(input string name, input int act, input int req, input int tol);
    n_cmp++;
    if (act - req > tol || req - act > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, req, tol);
    end
  endtask

  // Scoreboard: every done pulse pops one expectation
  initial begin
    exp_t e;
    int   zr;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && done) begin
        n_done++;
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done with empty scoreboard, want none");
        end else begin
          e  = sbq.pop_front();
          zr = int'($signed(z_res));
          check({e.name, "_x"}, int'($signed(x_out)), e.ex, TOL);
          check({e.name, "_y"}, int'($signed(y_out)), e.ey, TOL);
          check({e.name, "_zres"}, (zr < 0) ? -zr : zr, 0, TOL);
        end
      end
    end
  end

  task automatic push_exp(input int ex, input int ey, input string name);
    exp_t e;
    e.ex   = ex;
    e.ey   = ey;
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, "_latency"}, cyc, LAT, 0);
  endtask

  task automatic do_op(input int xi, input int yi, input int ai,
                       input int ex, input int ey, input string name);
    int cyc;
    @(negedge clk);
    x_in     = W'(xi);
    y_in     = W'(yi);
    angle_in = W'(ai);
    start    = 1'b1;
    push_exp(ex, ey, name);
    @(posedge clk);
    #1;
    check({name, "_busy_rise"}, int'(busy), 1, 0);
    @(negedge clk);
    start    = 1'b0;
    x_in     = W'($urandom);
    y_in     = W'($urandom);
    angle_in = W'($urandom);
    wait_done(name, cyc);
    @(posedge clk);
    #1;
    check({name, "_done_width"}, int'(done), 0, 0);
    check({name, "_busy_after"}, int'(busy), 0, 0);
  endtask

  vec_t tv[14];

  initial begin
    int cyc;
    int d0;

    tv[0]  = '{10000,      0,      0,  16468,      0,  10003,      0};
    tv[1]  = '{10000,      0,   8192,  11645,  11645,   7073,   7073};
    tv[2]  = '{10000,      0,  16384,      0,  16468,      0,  10003};
    tv[3]  = '{10000,      0, -32768, -16468,      0, -10003,      0};
    tv[4]  = '{10000,      0,  24576, -11645,  11645,  -7073,   7073};
    tv[5]  = '{    0,  10000,      0,      0,  16468,      0,  10003};
    tv[6]  = '{10000,      0,  -8192,  11645, -11645,   7073,  -7073};
    tv[7]  = '{-10000,     0,      0, -16468,      0, -10003,      0};
    tv[8]  = '{10000,      0, -16384,      0, -16468,      0, -10003};
    tv[9]  = '{20000,      0,      0,  32767,      0,  20006,      0};
    tv[10] = '{-20000,     0,      0, -32768,      0, -20006,      0};
    tv[11] = '{32767,  32767,      0,  32767,  32767,  32767,  32767};
    tv[12] = '{-32768, -32768,     0, -32768, -32768, -32768, -32768};
    tv[13] = '{10000,      0,  16385,     -2,  16468,     -1,  10003};

    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",  int'(busy),  0, 0);
    check("rst_done",  int'(done),  0, 0);
    check("rst_x_out", int'(x_out), 0, 0);
    check("rst_y_out", int'(y_out), 0, 0);
    check("rst_z_res", int'(z_res), 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
`ifdef CORDIC_GAIN_COMP_EN
      do_op(tv[i].xi, tv[i].yi, tv[i].ai, tv[i].ex_c, tv[i].ey_c, $sformatf("v%0d", i));
`else
      do_op(tv[i].xi, tv[i].yi, tv[i].ai, tv[i].ex_nc, tv[i].ey_nc, $sformatf("v%0d", i));
`endif
    end

    // start held high with changing operands for the whole rotation
    d0 = n_done;
    @(negedge clk);
    x_in     = W'(10000);
    y_in     = '0;
    angle_in = W'(8192);
    start    = 1'b1;
`ifdef CORDIC_GAIN_COMP_EN
    push_exp(7073, 7073, "hold");
`else
    push_exp(11645, 11645, "hold");
`endif
    @(posedge clk);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      x_in     = W'($urandom);
      y_in     = W'($urandom);
      angle_in = W'($urandom);
      start    = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("hold_latency", cyc, LAT, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("hold_done_count", n_done - d0, 1, 0);
    check("hold_sb_empty", sbq.size(), 0, 0);

    // reset in the middle of a rotation
    @(negedge clk);
    x_in     = W'(10000);
    y_in     = '0;
    angle_in = '0;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy",  int'(busy),  0, 0);
    check("abort_done",  int'(done),  0, 0);
    check("abort_x_out", int'(x_out), 0, 0);
    check("abort_y_out", int'(y_out), 0, 0);
    check("abort_z_res", int'(z_res), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef CORDIC_GAIN_COMP_EN
    do_op(10000, 0, 0, 10003, 0, "after_rst");
`else
    do_op(10000, 0, 0, 16468, 0, "after_rst");
`endif
    repeat (3) @(posedge clk);
    #1;
    check("final_sb_empty", sbq.size(), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
